// File: rtl/path_reader_pkg.sv
// Shared constants, state/error encodings and address helper for path_reader.
// PATH_REVERSE_EN selects the stacked (source-first) state set.
package path_reader_pkg;

  localparam int unsigned DEFAULT_MAX_NODES   = 16;
  localparam int unsigned DEFAULT_INDEX_WIDTH = 8;
  localparam int unsigned DEFAULT_MADDR_WIDTH = 16;
  localparam int unsigned DEFAULT_MDATA_WIDTH = 32;

  // Same all-ones marker the Dijkstra engine writes for "no predecessor".
  localparam logic [31:0] NO_PREVIOUS_NODE = '1;

`ifdef PATH_REVERSE_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_PUSH, ST_FETCH, ST_CHECK, ST_DONE, ST_ERROR, ST_POP
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_EMIT, ST_FETCH, ST_CHECK, ST_DONE, ST_ERROR
  } state_t;
`endif

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_BAD_ARG     = 2'd1,
    ERR_UNREACHABLE = 2'd2,
    ERR_BAD_INDEX   = 2'd3
  } error_code_t;

  function automatic int unsigned entry_stride(input int unsigned mdata_width);
    return mdata_width / 8;
  endfunction

endpackage

// File: rtl/path_reader_if.sv
// Memory read port and path stream bundle for path_reader.
interface path_reader_if import path_reader_pkg::*; #(
  parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int unsigned MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int unsigned MDATA_WIDTH = DEFAULT_MDATA_WIDTH
);
  logic                   mem_read_enable;
  logic [MADDR_WIDTH-1:0] mem_addr;
  logic                   mem_read_ready;
  logic [MDATA_WIDTH-1:0] mem_read_data;

  logic                   path_valid;
  logic                   path_ready;
  logic [INDEX_WIDTH-1:0] path_node;
  logic                   path_last;

  modport master (
    output mem_read_enable, mem_addr,
    input  mem_read_ready, mem_read_data,
    output path_valid, path_node, path_last,
    input  path_ready
  );

  modport slave (
    input  mem_read_enable, mem_addr,
    output mem_read_ready, mem_read_data,
    input  path_valid, path_node, path_last,
    output path_ready
  );
endinterface

// File: rtl/path_stack.sv
// Synchronous LIFO used to reverse the walked path (PATH_REVERSE_EN builds only).
module path_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign wr_idx  = AW'(count);
  assign top_idx = AW'(count - CW'(1));
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign top_data = empty ? '0 : mem[top_idx];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end
endmodule

// File: rtl/path_reader.sv
// Walks the Dijkstra predecessor vector from destination back to source and streams the nodes.
// Build option PATH_REVERSE_EN: buffer the walk in path_stack and stream source-first.
module path_reader import path_reader_pkg::*; #(
  parameter int unsigned MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int unsigned MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int unsigned MDATA_WIDTH = DEFAULT_MDATA_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] source,
  input  logic [INDEX_WIDTH-1:0] destination,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] result_address,
  path_reader_if.master          bus,
  output logic                   idle,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             error_code,
  output logic [INDEX_WIDTH-1:0] hop_count
);
  localparam int unsigned STRIDE = entry_stride(MDATA_WIDTH);
  localparam logic [INDEX_WIDTH-1:0] NO_PREV = NO_PREVIOUS_NODE[INDEX_WIDTH-1:0];
`ifdef PATH_REVERSE_EN
  localparam state_t ST_WALK = ST_PUSH;
`else
  localparam state_t ST_WALK = ST_EMIT;
`endif

  state_t                 state, state_next;
  error_code_t            err_r, err_next;
  logic [INDEX_WIDTH-1:0] node, node_next;
  logic [INDEX_WIDTH-1:0] hop_next;
  logic [INDEX_WIDTH-1:0] src_r, n_r, pred_r;
  logic [MADDR_WIDTH-1:0] base_r, entry_addr;
  logic                   at_source;
  logic                   unused_data_hi;

  assign unused_data_hi = ^bus.mem_read_data;
  assign at_source  = (node == src_r);
  assign entry_addr = base_r + MADDR_WIDTH'(node) * MADDR_WIDTH'(STRIDE);

`ifdef PATH_REVERSE_EN
  localparam int unsigned CW = $clog2(MAX_NODES+1);
  logic                   stack_push, stack_pop, stack_clear;
  logic                   stack_empty, stack_full;
  logic [INDEX_WIDTH-1:0] stack_top;
  logic [CW-1:0]          stack_count;
  logic                   stack_last;

  path_stack #(
    .DEPTH (MAX_NODES),
    .WIDTH (INDEX_WIDTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .clear     (stack_clear),
    .push      (stack_push),
    .pop       (stack_pop),
    .push_data (node),
    .top_data  (stack_top),
    .empty     (stack_empty),
    .full      (stack_full),
    .count     (stack_count)
  );

  // The destination is the bottom entry, so it is the last one popped.
  assign stack_last = (stack_count == CW'(1));
`else
  logic unused_cfg;
  assign unused_cfg = ^MAX_NODES;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      err_r     <= ERR_NONE;
      node      <= '0;
      hop_count <= '0;
      src_r     <= '0;
      n_r       <= '0;
      base_r    <= '0;
      pred_r    <= '0;
    end else begin
      state     <= state_next;
      err_r     <= err_next;
      node      <= node_next;
      hop_count <= hop_next;
      if (state == ST_IDLE && start) begin
        src_r  <= source;
        n_r    <= number_of_nodes;
        base_r <= result_address;
      end
      if (state == ST_FETCH && bus.mem_read_ready) begin
        pred_r <= bus.mem_read_data[INDEX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    err_next   = err_r;
    node_next  = node;
    hop_next   = hop_count;
`ifdef PATH_REVERSE_EN
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    stack_clear = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (source >= number_of_nodes || destination >= number_of_nodes) begin
            err_next   = ERR_BAD_ARG;
            state_next = ST_ERROR;
          end else begin
            err_next   = ERR_NONE;
            node_next  = destination;
            hop_next   = '0;
            state_next = ST_WALK;
`ifdef PATH_REVERSE_EN
            stack_clear = 1'b1;
`endif
          end
        end
      end
`ifdef PATH_REVERSE_EN
      ST_PUSH: begin
        if (stack_full) begin
          err_next   = ERR_BAD_INDEX;
          state_next = ST_ERROR;
        end else begin
          stack_push = 1'b1;
          hop_next   = hop_count + 1'b1;
          state_next = at_source ? ST_POP : ST_FETCH;
        end
      end
      ST_POP: begin
        if (bus.path_ready && !stack_empty) begin
          stack_pop = 1'b1;
          if (stack_last) state_next = ST_DONE;
        end
      end
`else
      ST_EMIT: begin
        if (bus.path_ready) begin
          hop_next   = hop_count + 1'b1;
          state_next = at_source ? ST_DONE : ST_FETCH;
        end
      end
`endif
      ST_FETCH: begin
        if (bus.mem_read_ready) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (pred_r == NO_PREV) begin
          err_next   = ERR_UNREACHABLE;
          state_next = ST_ERROR;
        end else if (pred_r >= n_r || hop_count >= n_r) begin
          err_next   = ERR_BAD_INDEX;
          state_next = ST_ERROR;
        end else begin
          node_next  = pred_r;
          state_next = ST_WALK;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_ERROR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign idle       = (state == ST_IDLE);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERROR);
  assign error_code = err_r;

  assign bus.mem_read_enable = (state == ST_FETCH);
  assign bus.mem_addr        = (state == ST_FETCH) ? entry_addr : '0;

`ifdef PATH_REVERSE_EN
  assign bus.path_valid = (state == ST_POP) && !stack_empty;
  assign bus.path_node  = (state == ST_POP) ? stack_top : node;
  assign bus.path_last  = (state == ST_POP) && stack_last;
`else
  assign bus.path_valid = (state == ST_EMIT);
  assign bus.path_node  = node;
  assign bus.path_last  = (state == ST_EMIT) && at_source;
`endif
endmodule

// File: tb/tb_path_reader.sv
// Bench for path_reader: directed vector table, reset/restart sequences and
// randomized walks compared against a predecessor-walk model.
module tb_path_reader;
  import path_reader_pkg::*;

  localparam int unsigned IW = 8, MAW = 16, MDW = 32, MAXN = 16;

  logic            clock = 1'b0;
  logic            reset, start;
  logic [IW-1:0]   source, destination, number_of_nodes;
  logic [MAW-1:0]  result_address;
  logic            idle, done, error;
  logic [1:0]      error_code;
  logic [IW-1:0]   hop_count;

  path_reader_if #(.INDEX_WIDTH(IW), .MADDR_WIDTH(MAW), .MDATA_WIDTH(MDW)) bus ();

  path_reader #(
    .MAX_NODES(MAXN), .INDEX_WIDTH(IW), .MADDR_WIDTH(MAW), .MDATA_WIDTH(MDW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .source(source),
    .destination(destination), .number_of_nodes(number_of_nodes),
    .result_address(result_address), .bus(bus), .idle(idle), .done(done),
    .error(error), .error_code(error_code), .hop_count(hop_count)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // environment state shared between the main flow and the responder
  logic [7:0]  prev_mem [16];
  logic [15:0] base_cur;
  int unsigned mem_delay, stall_cycles;
  bit          mem_rand, ready_rand;
  logic [15:0] exp_reads [$];
  logic [7:0]  got_nodes [$];
  bit          got_last  [$];
  int unsigned reads_seen, done_cnt, err_cnt;
  bit          ended;
  logic [1:0]  end_code;
  logic [7:0]  end_hop;

  // memory responder and stream consumer, all sampling on the falling edge
  initial begin
    bit          held_m, held_p;
    logic [15:0] held_addr, off;
    logic [7:0]  held_node;
    bit          held_last;
    int unsigned wcnt, cur_delay, stall;
    logic [31:0] word;
    held_m = 0; held_p = 0; wcnt = 0; cur_delay = 0; stall = 0;
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = '0;
    bus.path_ready     = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        bus.mem_read_ready = 1'b0;
        held_m = 0; held_p = 0; wcnt = 0; stall = 0;
        continue;
      end
      if (done) done_cnt++;
      if (error) err_cnt++;
      if ((done || error) && !ended) begin
        ended = 1; end_code = error_code; end_hop = hop_count;
      end

      if (bus.mem_read_ready) begin
        bus.mem_read_ready = 1'b0;
        check("rd_drop", bus.mem_read_enable, 0);
        held_m = 0;
      end else if (bus.mem_read_enable) begin
        if (held_m) begin
          check("addr_hold", bus.mem_addr, held_addr);
        end else begin
          held_m = 1; held_addr = bus.mem_addr; wcnt = 0;
          cur_delay = mem_rand ? $urandom_range(0, 4) : mem_delay;
          reads_seen++;
          if (exp_reads.size() == 0) check("extra_read", bus.mem_addr, 32'hFFFF_FFFF);
          else check("rd_addr", bus.mem_addr, exp_reads.pop_front());
        end
        if (wcnt >= cur_delay) begin
          off = bus.mem_addr - base_cur;
          word = $urandom();
          word[7:0] = (off[1:0] == 2'b00 && off[15:2] < 16) ? prev_mem[off[5:2]] : 8'hEE;
          bus.mem_read_data  = word;
          bus.mem_read_ready = 1'b1;
        end else begin
          wcnt++;
        end
      end else begin
        held_m = 0;
      end

      if (held_p) begin
        check("valid_hold", bus.path_valid, 1);
        check("node_hold", bus.path_node, held_node);
        check("last_hold", bus.path_last, held_last);
      end
      if (bus.path_valid) begin
        if (!held_p) stall = ready_rand ? $urandom_range(0, 2) : stall_cycles;
        bus.path_ready = (stall == 0);
        if (stall != 0) stall--;
        if (bus.path_ready) begin
          got_nodes.push_back(bus.path_node);
          got_last.push_back(bus.path_last);
          held_p = 0;
        end else begin
          held_p = 1; held_node = bus.path_node; held_last = bus.path_last;
        end
      end else begin
        bus.path_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        held_p = 0;
      end
    end
  end

  // Walked nodes (destination-first) the model/table expects for the next walk.
  logic [7:0] walk_q [$];
  logic [1:0] mdl_code;

  task automatic model(input logic [7:0] s, d, n);
    logic [7:0] cur, p;
    walk_q.delete();
    if (s >= n || d >= n) begin mdl_code = 2'd1; return; end
    cur = d;
    walk_q.push_back(d);
    forever begin
      if (cur == s) begin mdl_code = 2'd0; return; end
      p = prev_mem[cur[3:0]];
      if (p == 8'hFF) begin mdl_code = 2'd2; return; end
      if (p >= n || walk_q.size() >= n) begin mdl_code = 2'd3; return; end
      walk_q.push_back(p);
      cur = p;
    end
  endtask

  task automatic run_walk(input string tag, input logic [7:0] s, d, n,
                          input logic [15:0] base, input logic [1:0] ecode, input bit poke);
    logic [7:0] exp_s [$];
    int unsigned nreads, c;
    exp_reads.delete();
    foreach (walk_q[i])
      if (ecode != 0 || i < walk_q.size() - 1)
        exp_reads.push_back(base + 16'(walk_q[i]) * 16'd4);
    nreads = exp_reads.size();
`ifdef PATH_REVERSE_EN
    if (ecode == 0)
      for (int i = walk_q.size() - 1; i >= 0; i--) exp_s.push_back(walk_q[i]);
`else
    foreach (walk_q[i]) exp_s.push_back(walk_q[i]);
`endif
    got_nodes.delete(); got_last.delete();
    done_cnt = 0; err_cnt = 0; ended = 0; reads_seen = 0; base_cur = base;

    source = s; destination = d; number_of_nodes = n; result_address = base; start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    source = 8'($urandom()); destination = 8'($urandom());
    number_of_nodes = 8'($urandom()); result_address = 16'($urandom());
    for (c = 0; c < 1000 && !ended; c++) begin @(negedge clock); #1; end
    if (!ended) check({tag, ".timeout"}, 0, 1);
    if (poke) begin
      source = 2; destination = 2; number_of_nodes = 4; start = 1'b1;
      @(negedge clock); #1;
      start = 1'b0;
    end
    repeat (2) begin @(negedge clock); #1; end

    check({tag, ".done_cnt"}, done_cnt, (ecode == 0) ? 1 : 0);
    check({tag, ".err_cnt"}, err_cnt, (ecode != 0) ? 1 : 0);
    check({tag, ".code"}, end_code, ecode);
    check({tag, ".code_held"}, error_code, ecode);
    if (ecode != 1) check({tag, ".hops"}, end_hop, walk_q.size());
    check({tag, ".reads"}, reads_seen, nreads);
    check({tag, ".emits"}, got_nodes.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < got_nodes.size(); i++) begin
      check($sformatf("%s.node%0d", tag, i), got_nodes[i], exp_s[i]);
      check($sformatf("%s.last%0d", tag, i), got_last[i], (ecode == 0 && i == exp_s.size() - 1));
    end
    check({tag, ".idle"}, idle, 1);
  endtask

  typedef struct packed {
    logic [7:0]  src, dst, n;
    logic [31:0] prev;
    logic [15:0] base;
    logic [7:0]  mdelay, stall;
    logic [1:0]  code;
    logic [7:0]  len;
    logic [31:0] walk;
    logic        poke;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] s, d, n, input logic [31:0] prev4,
                              input logic [15:0] base, input logic [7:0] md, st,
                              input logic [1:0] code, input logic [7:0] len,
                              input logic [31:0] walk4, input logic poke);
    vec_t v;
    v.src = s; v.dst = d; v.n = n; v.prev = prev4; v.base = base;
    v.mdelay = md; v.stall = st; v.code = code; v.len = len; v.walk = walk4; v.poke = poke;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    for (int i = 0; i < 16; i++) prev_mem[i] = (i < 4) ? v.prev[i*8 +: 8] : 8'hFF;
    walk_q.delete();
    for (int i = 0; i < int'(v.len); i++) walk_q.push_back(v.walk[i*8 +: 8]);
    mem_delay = v.mdelay; stall_cycles = v.stall; mem_rand = 0; ready_rand = 0;
    run_walk(tag, v.src, v.dst, v.n, v.base, v.code, v.poke);
  endtask

  vec_t vt [8];

  initial begin
    logic [7:0] s, d, n;
    reset = 1'b1; start = 1'b0; source = '0; destination = '0;
    number_of_nodes = '0; result_address = '0;
    mem_delay = 0; stall_cycles = 0; mem_rand = 0; ready_rand = 0; base_cur = '0;
    for (int i = 0; i < 16; i++) prev_mem[i] = 8'hFF;
    repeat (3) @(negedge clock);
    #1;
    check("rst.idle", idle, 1);
    check("rst.rd_en", bus.mem_read_enable, 0);
    check("rst.addr", bus.mem_addr, 0);
    check("rst.valid", bus.path_valid, 0);
    check("rst.last", bus.path_last, 0);
    check("rst.node", bus.path_node, 0);
    check("rst.done", done, 0);
    check("rst.error", error, 0);
    check("rst.hops", hop_count, 0);
    check("rst.code", error_code, 0);
    reset = 1'b0;
    @(negedge clock); #1;

    // prev written as {p3,p2,p1,p0}; walk as destination-first bytes from the low end
    vt[0] = mk(0, 3, 4, 32'h010100FF, 16'h1000, 0, 0, 2'd0, 3, 32'h00000103, 1);
    vt[1] = mk(2, 2, 4, 32'h010100FF, 16'h1000, 0, 0, 2'd0, 1, 32'h00000002, 0);
    vt[2] = mk(0, 3, 4, 32'hFF0100FF, 16'h2000, 0, 0, 2'd2, 1, 32'h00000003, 1);
    vt[3] = mk(0, 1, 4, 32'h010102FF, 16'h1000, 0, 0, 2'd3, 4, 32'h02010201, 0);
    vt[4] = mk(0, 5, 4, 32'h010100FF, 16'h1000, 0, 0, 2'd1, 0, 32'h0, 0);
    vt[5] = mk(4, 0, 4, 32'h010100FF, 16'h1000, 0, 0, 2'd1, 0, 32'h0, 0);
    vt[6] = mk(0, 2, 3, 32'h000300FF, 16'h1000, 0, 0, 2'd3, 1, 32'h00000002, 0);
    vt[7] = mk(0, 3, 4, 32'h010100FF, 16'hFFF8, 5, 3, 2'd0, 3, 32'h00000103, 0);
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // reset while a read is outstanding, then a clean rerun
    for (int i = 0; i < 16; i++) prev_mem[i] = (i < 4) ? vt[0].prev[i*8 +: 8] : 8'hFF;
    mem_delay = 50; stall_cycles = 0; base_cur = 16'h1000;
    exp_reads.delete(); exp_reads.push_back(16'h100C);
    source = 0; destination = 3; number_of_nodes = 4; result_address = 16'h1000; start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && !bus.mem_read_enable; c++) begin @(negedge clock); #1; end
    check("rstf.fetching", bus.mem_read_enable, 1);
    reset = 1'b1;
    @(negedge clock); #1;
    check("rstf.idle", idle, 1);
    check("rstf.rd_en", bus.mem_read_enable, 0);
    check("rstf.valid", bus.path_valid, 0);
    check("rstf.hops", hop_count, 0);
    reset = 1'b0;
    @(negedge clock); #1;
    run_vec("rerun", vt[0]);

    // randomized graphs against the predecessor-walk model
    for (int t = 0; t < 40; t++) begin
      n = 8'($urandom_range(1, 12));
      s = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 13)) : 8'($urandom_range(0, n - 1));
      d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 13)) : 8'($urandom_range(0, n - 1));
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 19))
          0:       prev_mem[i] = 8'hFF;
          1:       prev_mem[i] = 8'($urandom_range(n, 30));
          default: prev_mem[i] = 8'($urandom_range(0, n - 1));
        endcase
      end
      mem_rand = 1; ready_rand = 1;
      model(s, d, n);
      run_walk($sformatf("rnd%0d", t), s, d, n, 16'($urandom()), mdl_code, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/path_reader.md
# path_reader

Reads back the predecessor vector that the Dijkstra engine writes to memory after a search, and walks it from `destination` to `source`. Each node on the shortest path is streamed out over a valid/ready handshake. The block sits on the same memory read port style as the edge cache, downstream of the result writer, and turns the raw result into a usable route for a host or display block.

## Interface
Parameters:
- `MAX_NODES`, `DEFAULT_MAX_NODES`: largest graph supported; bounds the hop count and the stack depth.
- `INDEX_WIDTH`, `DEFAULT_INDEX_WIDTH`: node index width.
- `MADDR_WIDTH`, `DEFAULT_MADDR_WIDTH`: memory address width.
- `MDATA_WIDTH`, `DEFAULT_MDATA_WIDTH`: memory word width; one predecessor entry per word, held in the low `INDEX_WIDTH` bits.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a walk; sampled only while `idle`=1.
- `source`  in  INDEX_WIDTH  path origin.
- `destination`  in  INDEX_WIDTH  path end.
- `number_of_nodes`  in  INDEX_WIDTH  graph size n.
- `result_address`  in  MADDR_WIDTH  byte address of entry 0.
- `mem_read_enable`  out  1  read request.
- `mem_addr`  out  MADDR_WIDTH  read address.
- `mem_read_ready`  in  1  read data valid this cycle.
- `mem_read_data`  in  MDATA_WIDTH  read data.
- `path_valid`  out  1  `path_node` is valid.
- `path_ready`  in  1  consumer accepts.
- `path_node`  out  INDEX_WIDTH  node on the path.
- `path_last`  out  1  final node of the path.
- `idle`  out  1  ready for `start`.
- `done`  out  1  one-cycle pulse when the walk completed successfully.
- `error`  out  1  one-cycle pulse when the walk aborted.
- `error_code`  out  2  0 none, 1 bad argument, 2 unreachable, 3 bad index or loop; held until the next `start`.
- `hop_count`  out  INDEX_WIDTH  nodes emitted (or pushed) in the current walk.

## Operation
- Entry i is located at byte address `result_address + i*(MDATA_WIDTH/8)`. The sum is computed in MADDR_WIDTH and wraps modulo 2^MADDR_WIDTH.
- An all-ones predecessor value is NO_PREVIOUS_NODE.
- States: IDLE, EMIT, FETCH, CHECK, DONE, ERROR, plus POP when reversal is enabled.
- **IDLE.** On `start`=1:
  - If `source`≥n or `destination`≥n, go to ERROR with code 1.
  - Otherwise set node=`destination`, set hop_count=0, and go to EMIT.
- **EMIT.** Drive `path_valid`=1 and `path_node`=node.
  - `path_last`=1 iff node==`source`.
  - On the handshake, hop_count increments.
  - If `path_last`=1, go to DONE; otherwise go to FETCH.
- **FETCH.** Drive `mem_read_enable`=1 with `mem_addr` for entry node. On `mem_read_ready`=1, capture the data and go to CHECK.
- **CHECK.** Let p be the low INDEX_WIDTH bits of the captured data.
  - If p==NO_PREVIOUS_NODE, go to ERROR with code 2.
  - Else if p≥n or hop_count≥n, go to ERROR with code 3.
  - Otherwise set node=p and go to EMIT.
- **DONE / ERROR.** Pulse `done` or `error` for one cycle, then go to IDLE.
- `source`==`destination`: a single EMIT with `path_last`=1. No memory read is issued.
- Inputs are registered on `start`. Later changes to the inputs have no effect on the walk in progress.

## Timing
- Reset values:
  - `idle`=1.
  - `mem_read_enable`, `path_valid`, `path_last`, `done`, `error` = 0.
  - `mem_addr`, `path_node`, `hop_count`, `error_code` = 0.
- Reset mid-walk: the state returns to IDLE at the next edge. Any outstanding read is abandoned; its `mem_read_ready` is ignored in IDLE.
- Memory handshake: `mem_read_enable` and `mem_addr` stay stable until `mem_read_ready` is sampled high. `mem_read_enable` drops in the following cycle.
- Stream handshake: `path_node` and `path_last` stay stable while `path_valid`=1 and `path_ready`=0.
- Minimum latency per hop is 3 cycles (EMIT, FETCH, CHECK) with zero-wait memory and a consumer that is always ready.
- `idle`=1 only in IDLE. A `start` asserted during DONE or ERROR is ignored.

## Configuration
- `PATH_REVERSE_EN` defined:
  - EMIT is replaced by PUSH. Nodes are pushed onto a MAX_NODES-deep LIFO, with no stream output during the walk.
  - After `source` is pushed, the block enters POP and emits in source-to-destination order. `path_last`=1 on `destination`.
  - All errors are therefore detected before any node is emitted; an aborted walk emits nothing.
  - Stack overflow maps to code 3.
- `PATH_REVERSE_EN` undefined: no LIFO is built, and nodes are emitted destination-first as they are walked.

## Structure
- The shared constants package holds:
  - the state enum;
  - the error-code enum;
  - NO_PREVIOUS_NODE, matching the value the Dijkstra engine uses as its no-predecessor marker;
  - the entry-stride helper (`MDATA_WIDTH/8`).
- One sub-module, `path_stack`: a synchronous LIFO with push, pop, empty and full. It is instantiated only under `PATH_REVERSE_EN`.

## Test plan
- n=4, src=0, dst=3, prev=[FF,0,1,1], zero-wait memory, `path_ready`=1 → emits 3, 1, 0; `path_last` on 0; `done` pulse; hop_count=3. With the macro defined → emits 0, 1, 3.
- src=dst=2 → single emit of 2 with `path_last`=1; `mem_read_enable` never asserted; `done` pulse.
- prev[3]=FF, dst=3, src=0 → emits 3, then `error` pulse with code 2. With the macro defined → no emits, code 2.
- prev[1]=2, prev[2]=1, dst=1, src=0, n=4 → `error` with code 3 once hop_count reaches 4. With dst=5 → immediate code 1 and no reads.
- `path_ready` held low for 3 cycles and `mem_read_ready` delayed 5 cycles → `path_node`, `mem_addr` and `mem_read_enable` remain stable; result is identical to the first scenario.
- `reset` asserted during FETCH → next cycle `idle`=1 and `mem_read_enable`=0; a new `start` completes the first scenario correctly.
